// File: rtl/alib_code_packer_if.sv
// Rank-in / packed-word-out bundle for the octree code packer.
// The master modport drives ranks, flush and word_ready. The slave modport is the packer side.
interface alib_code_packer_if #(
  parameter int RANK_W = 8,
  parameter int OUT_W  = 32,
  parameter int BITS_W = $clog2(OUT_W + 1)
);
  logic              i_valid;
  logic              o_ready;
  logic [RANK_W-1:0] i_rank;
  logic              i_flush;
  logic              o_word_valid;
  logic              i_word_ready;
  logic [OUT_W-1:0]  o_word;
  logic [BITS_W-1:0] o_word_bits;
  logic              o_word_last;
  logic              o_flush_done;
  logic              o_err_range;

  modport master (
    output i_valid, i_rank, i_flush, i_word_ready,
    input  o_ready, o_word_valid, o_word, o_word_bits, o_word_last, o_flush_done, o_err_range
  );

  modport slave (
    input  i_valid, i_rank, i_flush, i_word_ready,
    output o_ready, o_word_valid, o_word, o_word_bits, o_word_last, o_flush_done, o_err_range
  );
endinterface

// File: rtl/alib_code_packer.sv
// Maps ranks to 5-tier prefix codes and packs them MSB-first into OUT_W-bit words.
// Zero-latency encode into a 2*OUT_W left-aligned accumulator; explicit flush emits a padded tail word.
module alib_code_packer #(
  parameter int RANK_W = 8,
  parameter int OUT_W  = 32,
  parameter int SUF0   = 2,
  parameter int SUF1   = 3,
  parameter int SUF2   = 4,
  parameter int SUF3   = 6,
  parameter int SUF4   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alib_code_packer_if.slave  pk
);
  localparam int BUF_W  = 2 * OUT_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int BITS_W = $clog2(OUT_W + 1);
  localparam int B1  = 1 << SUF0;
  localparam int B2  = B1 + (1 << SUF1);
  localparam int B3  = B2 + (1 << SUF2);
  localparam int B4  = B3 + (1 << SUF3);
  localparam int CAP = B4 + (1 << SUF4);
  localparam int L0 = 1 + SUF0;
  localparam int L1 = 2 + SUF1;
  localparam int L2 = 3 + SUF2;
  localparam int L3 = 4 + SUF3;
  localparam int L4 = 5 + SUF4;
  // Longest code over all tiers, so a non-monotonic suffix set can never overflow the buffer.
  localparam int M01 = (L0 > L1) ? L0 : L1;
  localparam int M23 = (L2 > L3) ? L2 : L3;
  localparam int M03 = (M01 > M23) ? M01 : M23;
  localparam int MAX_LEN = (M03 > L4) ? M03 : L4;

  typedef enum logic [1:0] {RUN, DRAIN, TAIL} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               err_q, err_d;

  logic [31:0]        rank_ext;
  logic [BUF_W-1:0]   code_al;
  logic [FILL_W-1:0]  code_len;
  logic               in_range;

  logic               ready_c, word_valid_c, word_last_c, flush_done_c;
  logic [OUT_W-1:0]   word_c;
  logic [BITS_W-1:0]  word_bits_c;
  logic               pop, push;
  logic [BUF_W-1:0]   acc_base;
  logic [FILL_W-1:0]  fill_base;

  function automatic logic [BUF_W-1:0] align_code(input int pfx, input int suf_w,
                                                  input int len, input logic [31:0] off);
    logic [BUF_W-1:0] v;
    v = (BUF_W'(pfx) << suf_w) | BUF_W'(off);
    return v << (BUF_W - len);
  endfunction

  always_comb begin
    rank_ext = 32'(pk.i_rank);
    in_range = 1'b1;
    code_len = '0;
    code_al  = '0;
    if (rank_ext < B1) begin
      code_len = FILL_W'(L0);
      code_al  = align_code(0, SUF0, L0, rank_ext);
    end else if (rank_ext < B2) begin
      code_len = FILL_W'(L1);
      code_al  = align_code(2, SUF1, L1, rank_ext - B1);
    end else if (rank_ext < B3) begin
      code_len = FILL_W'(L2);
      code_al  = align_code(6, SUF2, L2, rank_ext - B2);
    end else if (rank_ext < B4) begin
      code_len = FILL_W'(L3);
      code_al  = align_code(14, SUF3, L3, rank_ext - B3);
    end else if (rank_ext < CAP) begin
      code_len = FILL_W'(L4);
      code_al  = align_code(30, SUF4, L4, rank_ext - B4);
    end else begin
      in_range = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    err_d        = err_q;
    word_valid_c = 1'b0;
    word_last_c  = 1'b0;
    word_bits_c  = '0;
    word_c       = '0;
    flush_done_c = 1'b0;
    ready_c      = !rst_i && (state_q == RUN) && (fill_q <= FILL_W'(BUF_W - MAX_LEN));

    case (state_q)
      RUN, DRAIN: word_valid_c = (fill_q >= FILL_W'(OUT_W));
      TAIL: begin
        word_valid_c = 1'b1;
        word_last_c  = 1'b1;
      end
      default: word_valid_c = 1'b0;
    endcase
    if (word_valid_c) begin
      word_c      = acc_q[BUF_W-1 -: OUT_W];
      word_bits_c = word_last_c ? BITS_W'(fill_q) : BITS_W'(OUT_W);
    end

    pop  = word_valid_c && pk.i_word_ready;
    push = ready_c && pk.i_valid;

    if (pop && state_q == TAIL) begin
      acc_base  = '0;
      fill_base = '0;
    end else if (pop) begin
      acc_base  = acc_q << OUT_W;
      fill_base = fill_q - FILL_W'(OUT_W);
    end else begin
      acc_base  = acc_q;
      fill_base = fill_q;
    end

    acc_d  = acc_base;
    fill_d = fill_base;
    if (push) begin
      if (in_range) begin
        acc_d  = acc_base | (code_al >> fill_base);
        fill_d = fill_base + code_len;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      RUN: if (pk.i_flush) state_d = DRAIN;
      DRAIN: begin
        if (fill_q < FILL_W'(OUT_W)) begin
          if (fill_q == '0) begin
            flush_done_c = 1'b1;
            state_d      = RUN;
          end else begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (pop) begin
          flush_done_c = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  assign pk.o_ready      = ready_c;
  assign pk.o_word_valid = word_valid_c;
  assign pk.o_word       = word_c;
  assign pk.o_word_bits  = word_bits_c;
  assign pk.o_word_last  = word_last_c;
  assign pk.o_flush_done = flush_done_c;
  assign pk.o_err_range  = err_q;
endmodule

// File: tb/tb_alib_code_packer.sv
// Bench for alib_code_packer: reference encoder feeds an expected-word queue; a negedge monitor pops and compares.
module tb_alib_code_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alib_code_packer_if #(.RANK_W(8), .OUT_W(32)) bus ();
  alib_code_packer_if #(.RANK_W(8), .OUT_W(32)) bus_s ();

  alib_code_packer #(.RANK_W(8), .OUT_W(32)) dut (.clk_i(clk), .rst_i(rst), .pk(bus));
  alib_code_packer #(.RANK_W(8), .OUT_W(32), .SUF4(4)) dut_s (.clk_i(clk), .rst_i(rst), .pk(bus_s));

  typedef struct {
    logic [31:0] w;
    int          bits;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  bit          mbits[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          words_seen = 0;
  logic [31:0] last_w;
  int          last_bits;
  bit          last_last;

  function automatic void enc(input int r, output logic [31:0] code, output int len, output bit err);
    int suf[5];
    int base;
    suf  = '{2, 3, 4, 6, 8};
    base = 0;
    err  = 1'b1;
    code = '0;
    len  = 0;
    for (int k = 0; k < 5; k++) begin
      if (err && r < base + (1 << suf[k])) begin
        len  = k + 1 + suf[k];
        code = (((32'd1 << (k + 1)) - 32'd2) << suf[k]) | 32'(r - base);
        err  = 1'b0;
      end
      base += (1 << suf[k]);
    end
  endfunction

  function automatic void model_push(input int r);
    logic [31:0] code;
    int len;
    bit err;
    exp_t e;
    enc(r, code, len, err);
    if (!err)
      for (int i = len - 1; i >= 0; i--) mbits.push_back(code[i]);
    while (mbits.size() >= 32) begin
      e.w = '0;
      for (int i = 0; i < 32; i++) e.w[31-i] = mbits.pop_front();
      e.bits = 32;
      e.last = 1'b0;
      expq.push_back(e);
    end
  endfunction

  function automatic void model_flush();
    exp_t e;
    int n;
    n = mbits.size();
    if (n > 0) begin
      e.w = '0;
      for (int i = 0; i < n; i++) e.w[31-i] = mbits.pop_front();
      e.bits = n;
      e.last = 1'b1;
      expq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_valid && bus.o_ready) model_push(int'(bus.i_rank));
      if (bus.i_flush) model_flush();
      if (bus.o_word_valid && bus.i_word_ready) begin
        exp_t e;
        words_seen++;
        last_w    = bus.o_word;
        last_bits = int'(bus.o_word_bits);
        last_last = bus.o_word_last;
        n_checks++;
        if (expq.size() == 0) begin
          $display("FAIL unexpected_word got=%h bits=%0d, no word expected", bus.o_word, bus.o_word_bits);
        end else begin
          n_pass++;
          e = expq.pop_front();
          n_checks++;
          if (bus.o_word !== e.w) $display("FAIL word got=%h exp=%h", bus.o_word, e.w);
          else n_pass++;
          n_checks++;
          if (int'(bus.o_word_bits) !== e.bits) $display("FAIL word_bits got=%0d exp=%0d", bus.o_word_bits, e.bits);
          else n_pass++;
          n_checks++;
          if (bus.o_word_last !== e.last) $display("FAIL word_last got=%b exp=%b", bus.o_word_last, e.last);
          else n_pass++;
        end
      end
      if (bus.o_flush_done) done_cnt++;
    end
  end

  task automatic send_rank(input int r);
    int t;
    bus.i_valid = 1'b1;
    bus.i_rank  = 8'(r);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.o_ready && t < 300);
    if (!bus.o_ready) begin
      n_checks++;
      $display("FAIL send_timeout rank=%0d got ready=0 exp ready=1", r);
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic do_flush(input bit with_rank, input int r);
    int c0;
    int t;
    c0 = done_cnt;
    bus.i_flush = 1'b1;
    if (with_rank) begin
      bus.i_valid = 1'b1;
      bus.i_rank  = 8'(r);
      @(negedge clk);
      n_checks++;
      if (bus.o_ready !== 1'b1) $display("FAIL flush_accept_ready got=%b exp=1", bus.o_ready);
      else n_pass++;
    end
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    t = 0;
    while (done_cnt == c0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt !== c0 + 1) $display("FAIL flush_done_pulses got=%0d exp=1", done_cnt - c0);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.o_ready !== 1'b0 || bus.o_word_valid !== 1'b0 || bus.o_flush_done !== 1'b0)
      $display("FAIL reset_ctrl got ready=%b wv=%b fd=%b exp 0/0/0", bus.o_ready, bus.o_word_valid, bus.o_flush_done);
    else n_pass++;
    n_checks++;
    if (bus.o_word !== 32'h0 || bus.o_word_bits !== 6'd0 || bus.o_word_last !== 1'b0)
      $display("FAIL reset_word got word=%h bits=%0d last=%b exp 0/0/0", bus.o_word, bus.o_word_bits, bus.o_word_last);
    else n_pass++;
    n_checks++;
    if (bus.o_err_range !== 1'b0 || bus_s.o_err_range !== 1'b0)
      $display("FAIL reset_err got %b/%b exp 0/0", bus.o_err_range, bus_s.o_err_range);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", bus.o_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_small_ranks();
    for (int i = 0; i < 4; i++) send_rank(i);
    do_flush(1'b0, 0);
    n_checks++;
    if (last_w !== 32'h05300000 || last_bits !== 12 || last_last !== 1'b1)
      $display("FAIL ranks0to3 got word=%h bits=%0d last=%b exp 05300000/12/1", last_w, last_bits, last_last);
    else n_pass++;
  endtask

  task automatic test_tiers();
    int w0;
    int rk[5];
    rk = '{4, 12, 28, 92, 255};
    w0 = words_seen;
    foreach (rk[i]) send_rank(rk[i]);
    do_flush(1'b0, 0);
    n_checks++;
    if (words_seen - w0 !== 2 || last_bits !== 16 || last_last !== 1'b1)
      $display("FAIL tiers_shape got words=%0d tail_bits=%0d exp words=2 tail_bits=16", words_seen - w0, last_bits);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc;
    bus.i_word_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_rank  = 8'd255;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.o_ready) break;
      acc++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    n_checks++;
    if (acc !== 4) $display("FAIL accepts_before_stall got=%0d exp=4", acc);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_word_valid !== 1'b1 || expq.size() == 0 || bus.o_word !== expq[0].w)
      $display("FAIL stalled_word got wv=%b word=%h, exp wv=1 and model head word", bus.o_word_valid, bus.o_word);
    else n_pass++;
    n_checks++;
    if (bus.o_ready !== 1'b0) $display("FAIL ready_while_full got=%b exp=0", bus.o_ready);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_word_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) $display("FAIL ready_after_pop got=%b exp=1", bus.o_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    do_flush(1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = words_seen;
    for (int i = 0; i < 8; i++) send_rank(255);
    do_flush(1'b0, 0);
    n_checks++;
    if (words_seen - w0 !== 4 || last_bits !== 8 || last_last !== 1'b1)
      $display("FAIL b2b_shape got words=%0d tail_bits=%0d exp words=4 tail_bits=8", words_seen - w0, last_bits);
    else n_pass++;
  endtask

  task automatic test_flush_edges();
    int w0;
    do_flush(1'b1, 5);
    n_checks++;
    if (last_w !== 32'h88000000 || last_bits !== 5)
      $display("FAIL flush_with_accept got word=%h bits=%0d exp 88000000/5", last_w, last_bits);
    else n_pass++;
    w0 = words_seen;
    do_flush(1'b0, 0);
    n_checks++;
    if (words_seen !== w0) $display("FAIL empty_flush_words got=%0d exp=0", words_seen - w0);
    else n_pass++;
  endtask

  task automatic test_err_range();
    int t;
    bus_s.i_valid = 1'b1;
    bus_s.i_rank  = 8'd200;
    @(negedge clk);
    @(posedge clk);
    #1 bus_s.i_rank = 8'd0;
    n_checks++;
    if (bus_s.o_err_range !== 1'b1 || bus_s.o_ready !== 1'b1 || bus_s.o_word_valid !== 1'b0)
      $display("FAIL err_after_200 got err=%b ready=%b wv=%b exp 1/1/0", bus_s.o_err_range, bus_s.o_ready, bus_s.o_word_valid);
    else n_pass++;
    @(posedge clk);
    #1 bus_s.i_valid = 1'b0;
    bus_s.i_flush = 1'b1;
    @(posedge clk);
    #1 bus_s.i_flush = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus_s.o_word_valid && t < 20);
    n_checks++;
    if (bus_s.o_word !== 32'h0 || bus_s.o_word_bits !== 6'd3 || bus_s.o_word_last !== 1'b1 || bus_s.o_flush_done !== 1'b1)
      $display("FAIL err_tail got word=%h bits=%0d last=%b fd=%b exp 0/3/1/1", bus_s.o_word, bus_s.o_word_bits, bus_s.o_word_last, bus_s.o_flush_done);
    else n_pass++;
    n_checks++;
    if (bus.o_err_range !== 1'b0) $display("FAIL main_err got=%b exp=0", bus.o_err_range);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_flush();
    int t;
    send_rank(28);
    send_rank(12);
    send_rank(0);
    bus.i_word_ready = 1'b0;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.o_word_valid && bus.o_word_last) && t < 20);
    n_checks++;
    if (bus.o_word_bits !== 6'd20) $display("FAIL tail_fill got=%0d exp=20", bus.o_word_bits);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_word_valid !== 1'b0 || bus.o_word !== 32'h0 || bus.o_word_bits !== 6'd0 || bus.o_word_last !== 1'b0 || bus.o_ready !== 1'b0)
      $display("FAIL async_reset got wv=%b word=%h bits=%0d last=%b ready=%b exp all 0", bus.o_word_valid, bus.o_word, bus.o_word_bits, bus.o_word_last, bus.o_ready);
    else n_pass++;
    n_checks++;
    if (bus_s.o_err_range !== 1'b0) $display("FAIL err_cleared_by_reset got=%b exp=0", bus_s.o_err_range);
    else n_pass++;
    expq.delete();
    mbits.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_word_ready = 1'b1;
    send_rank(1);
    do_flush(1'b0, 0);
    n_checks++;
    if (last_w !== 32'h20000000 || last_bits !== 3)
      $display("FAIL after_reset_word got word=%h bits=%0d exp 20000000/3", last_w, last_bits);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_rank = '0;
    bus.i_flush = 1'b0;
    bus.i_word_ready = 1'b1;
    bus_s.i_valid = 1'b0;
    bus_s.i_rank = '0;
    bus_s.i_flush = 1'b0;
    bus_s.i_word_ready = 1'b1;
    test_reset();
    test_small_ranks();
    test_tiers();
    test_backpressure();
    test_back_to_back();
    test_flush_edges();
    test_err_range();
    test_reset_mid_flush();
    n_checks++;
    if (expq.size() !== 0) $display("FAIL leftover_words got=%0d exp=0", expq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
